fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_pkg.sv | 16 +
 rtl/uart_bit_timer.sv | 30 +++
 rtl/fifo_uart_tx.sv | 105 ++++++++++
 tb/tb_fifo_uart_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding and default timing.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_e;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_STOP_BITS    = 1;

endpackage

// File: rtl/uart_bit_timer.sv
// Serial bit-period timer: counts 0..CLKS_PER_BIT-1, ticks on terminal count.
module uart_bit_timer
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic in_clock,
    input  logic in_reset,
    input  logic in_restart,
    output logic out_tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign out_tick = (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (in_restart || out_tick) cnt_d = '0;
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO via take/empty and serialises each word as a UART frame
// (start, LSB-first data, optional even parity, 1 or 2 stop bits).
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = DEF_STOP_BITS
) (
    input  logic                  in_clock,
    input  logic                  in_reset,
    input  logic                  in_enable,
    input  logic                  in_empty,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_take,
    output logic                  out_tx,
    output logic                  out_busy
);

    // Index counter is shared between data bits and stop bits.
    localparam int IW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    uart_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  tx_q, tx_d;
    logic                  tick;
    logic                  restart;

    assign out_take = (state_q == ST_IDLE) & in_enable & ~in_empty & ~in_reset;
    assign out_busy = (state_q != ST_IDLE);
    assign out_tx   = tx_q;
    assign restart  = (state_d != state_q);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .in_clock   (in_clock),
        .in_reset   (in_reset),
        .in_restart (restart),
        .out_tick   (tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        idx_d    = idx_q;
        unique case (state_q)
            ST_IDLE: if (out_take) state_d = ST_LOAD;
            ST_LOAD: begin
                shift_d  = in_data;
                parity_d = ^in_data;
                idx_d    = '0;
                state_d  = ST_START;
            end
            ST_START: if (tick) state_d = ST_DATA;
            ST_DATA: if (tick) begin
                shift_d = shift_q >> 1;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST_BIT) begin
                    idx_d   = '0;
                    state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP: if (tick) begin
                idx_d = idx_q + IW'(1);
                if (idx_q == LAST_STOP) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level is derived from the next state so the registered output lines up with it.
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   ;
        endcase
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
            idx_q    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Three transmitter configurations fed by a behavioural FIFO; per-instance monitors
// decode frames and compare them with words queued when the FIFO was loaded.
module tb_fifo_uart_tx;

    localparam int CPB_A [3] = '{4, 4, 2};
    localparam int PAR_A [3] = '{0, 1, 0};
    localparam int SB_A  [3] = '{1, 1, 2};

    typedef struct {
        int         inst;
        logic [7:0] word;
    } sb_t;

    logic       clk;
    logic       rst;
    logic [2:0] en;
    logic [2:0] empty;
    logic [2:0] take;
    logic [2:0] tx;
    logic [2:0] busy;
    logic [7:0] rdata [3];
    logic [7:0] fmem  [3][16];
    int         wp [3] = '{0, 0, 0};
    int         rp [3] = '{0, 0, 0};
    sb_t        exp_q [$];
    int         n_chk = 0;
    int         n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push(input int g, input logic [7:0] w);
        sb_t e;
        fmem[g][wp[g] % 16] = w;
        wp[g]++;
        e.inst = g;
        e.word = w;
        exp_q.push_back(e);
    endtask

    always_comb begin
        empty = '0;
        for (int i = 0; i < 3; i++) empty[i] = (wp[i] == rp[i]);
    end

    // FIFO read data is registered on the take edge.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (take[i]) begin
                rdata[i] <= fmem[i][rp[i] % 16];
                rp[i]    <= rp[i] + 1;
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int CPB = CPB_A[g];
        localparam int PAR = PAR_A[g];
        localparam int SB  = SB_A[g];
        localparam int NB  = 1 + 8 + PAR + SB;

        fifo_uart_tx #(
            .DATA_WIDTH   (8),
            .CLKS_PER_BIT (CPB),
            .PARITY_EN    (PAR),
            .STOP_BITS    (SB)
        ) dut (
            .in_clock  (clk),
            .in_reset  (rst),
            .in_enable (en[g]),
            .in_empty  (empty[g]),
            .in_data   (rdata[g]),
            .out_take  (take[g]),
            .out_tx    (tx[g]),
            .out_busy  (busy[g])
        );

        initial begin : mon
            sb_t  e;
            bit   ab, skip, bit_ok, busy_ok;
            int   tk;
            logic v, eb;
            skip = 0;
            forever begin
                if (!skip) @(negedge clk);
                skip = 0;
                if (rst || !take[g]) continue;
                chk($sformatf("g%0d_take_nonempty", g), int'(empty[g]), 0);
                if (exp_q.size() == 0) begin
                    chk($sformatf("g%0d_take_unexpected", g), 1, 0);
                    continue;
                end
                e = exp_q.pop_front();
                chk($sformatf("g%0d_sb_inst", g), e.inst, g);
                @(negedge clk);
                if (rst) continue;
                chk($sformatf("g%0d_load_take", g), int'(take[g]), 0);
                chk($sformatf("g%0d_load_tx", g), int'(tx[g]), 1);
                chk($sformatf("g%0d_load_busy", g), int'(busy[g]), 1);
                ab = 0; tk = 0; busy_ok = 1;
                for (int k = 0; k < NB && !ab; k++) begin
                    if (k == 0)             eb = 1'b0;
                    else if (k <= 8)        eb = e.word[k-1];
                    else if (PAR && k == 9) eb = ^e.word;
                    else                    eb = 1'b1;
                    bit_ok = 1; v = 1'b0;
                    for (int c = 0; c < CPB; c++) begin
                        @(negedge clk);
                        if (rst) begin ab = 1; break; end
                        if (c == 0) v = tx[g];
                        else if (tx[g] !== v) bit_ok = 0;
                        if (!busy[g]) busy_ok = 0;
                        if (take[g]) tk++;
                    end
                    if (!ab)
                        chk($sformatf("g%0d_w%02h_bit%0d", g, e.word, k),
                            bit_ok ? int'(v) : 2, int'(eb));
                end
                if (ab) continue;
                chk($sformatf("g%0d_frame_busy", g), int'(busy_ok), 1);
                chk($sformatf("g%0d_frame_take", g), tk, 0);
                @(negedge clk);
                if (rst) continue;
                chk($sformatf("g%0d_idle_busy", g), int'(busy[g]), 0);
                chk($sformatf("g%0d_idle_tx", g), int'(tx[g]), 1);
                chk($sformatf("g%0d_idle_take", g), int'(take[g]), int'(en[g] & ~empty[g]));
                skip = 1;
            end
        end
    end

    task automatic wait_idle(input int g, input int max_cyc);
        int quiet, n;
        quiet = 0; n = 0;
        while (quiet < 3 && n < max_cyc) begin
            @(negedge clk);
            n++;
            if (!busy[g] && !take[g]) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) chk($sformatf("g%0d_idle_timeout", g), 0, 1);
    endtask

    task automatic wait_take(input int g);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!take[g] && n < 200);
        if (!take[g]) chk($sformatf("g%0d_take_timeout", g), 0, 1);
    endtask

    initial begin
        int nt, nl, base;
        rst = 1'b0;
        en  = '0;
        #1 rst = 1'b1;
        push(0, 8'hA5);
        en[0] = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_tx%0d", i), int'(tx[i]), 1);
            chk($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
            chk($sformatf("rst_take%0d", i), int'(take[i]), 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        wait_idle(0, 200);
        chk("t1_takes", rp[0], 1);

        @(posedge clk); #1;
        push(1, 8'h07);
        push(1, 8'hA5);
        en[1] = 1'b1;
        wait_idle(1, 300);
        chk("t2_takes", rp[1], 2);

        @(posedge clk); #1;
        en[0] = 1'b0;
        @(posedge clk); #1;
        en[0] = 1'b1;
        #1 chk("en_rise_empty_take", int'(take[0]), 0);
        en[0] = 1'b0;
        push(0, 8'h12);
        push(0, 8'h34);
        push(0, 8'hC3);
        nt = 0; nl = 0;
        repeat (20) begin
            @(negedge clk);
            if (take[0]) nt++;
            if (!tx[0]) nl++;
        end
        chk("dis_takes", nt, 0);
        chk("dis_tx_low", nl, 0);
        @(posedge clk); #1 en[0] = 1'b1;
        wait_idle(0, 600);
        chk("t3_takes", rp[0], 4);
        chk("t3_empty", int'(empty[0]), 1);

        @(posedge clk); #1 en[0] = 1'b0;
        @(posedge clk); #1;
        push(0, 8'h96);
        en[0] = 1'b1;
        #1 chk("same_cycle_take", int'(take[0]), 1);
        wait_idle(0, 200);
        chk("t3b_takes", rp[0], 5);

        base = rp[0];
        @(posedge clk); #1;
        push(0, 8'h3C);
        push(0, 8'h5A);
        wait_take(0);
        repeat (19) @(posedge clk);
        #1 chk("pre_rst_busy", int'(busy[0]), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_tx", int'(tx[0]), 1);
        chk("async_rst_busy", int'(busy[0]), 0);
        chk("async_rst_take", int'(take[0]), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_idle(0, 200);
        chk("t4_takes", rp[0], base + 2);

        @(posedge clk); #1;
        push(2, 8'hFF);
        push(2, 8'hFF);
        en[2] = 1'b1;
        wait_take(2);
        repeat (6) @(posedge clk);
        #1 en[2] = 1'b0;
        wait_idle(2, 200);
        chk("t5_takes", rp[2], 1);
        chk("t5_left", exp_q.size(), 1);
        exp_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
